// File: rtl/adder_pipe_sat_pkg.sv
// Shared definitions for the pipelined saturating add/subtract unit.
// Holds the default operand width, the saturation limits and the helpers
// that carve the carry chain into per-stage segments.
package adder_pkg;

  localparam int DEF_WIDTH = 23;

  // Nominal segment width: ceil(w / n).
  function automatic int seg_size(input int w, input int n);
    return (w + n - 1) / n;
  endfunction

  // Lowest bit position covered by segment k.
  function automatic int seg_lo(input int k, input int seg);
    return k * seg;
  endfunction

  // Width of segment k; the top segment may be narrower, and segments that
  // start beyond the operand width are empty (they only forward the carry).
  function automatic int seg_w(input int k, input int seg, input int w);
    int lo;
    lo = k * seg;
    if (lo >= w) return 0;
    else if (w - lo < seg) return w - lo;
    else return seg;
  endfunction

  // Largest positive two's-complement value of width w (w <= 64).
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of width w, as a raw bit pattern.
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/adder_pipe_sat_seg.sv
// One carry-chain segment of the skewed adder pipeline.
// Adds the SW-bit operand slice plus carry-in combinationally and owns the
// stage valid flag together with its advance/ready handshake.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   valid_i         upstream stage (or source) holds an operation
//   down_ready_i    downstream stage can take this stage's contents
//   valid_o         this stage holds an operation
//   ready_o         this stage can take a new operation this cycle
//   load_o          data registers of this stage must capture this cycle
//   a_i, b_i, c_i   operand slices and carry-in for this segment
//   s_o, c_o        segment sum and carry-out
module adder_seg #(
  parameter int SW  = 1,
  parameter int SWP = (SW > 0) ? SW : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           valid_i,
  input  logic           down_ready_i,
  output logic           valid_o,
  output logic           ready_o,
  output logic           load_o,
  input  logic [SWP-1:0] a_i,
  input  logic [SWP-1:0] b_i,
  input  logic           c_i,
  output logic [SWP-1:0] s_o,
  output logic           c_o
);

  logic vld_q;
  logic adv;

  assign adv     = vld_q & down_ready_i;
  // A stage that empties this cycle can refill in the same cycle.
  assign ready_o = !vld_q | adv;
  assign load_o  = ready_o & valid_i;
  assign valid_o = vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
    end else if (ready_o) begin
      vld_q <= valid_i;
    end
  end

  if (SW > 0) begin : g_add
    logic [SW:0] t;
    assign t   = {1'b0, a_i} + {1'b0, b_i} + {{SW{1'b0}}, c_i};
    assign s_o = t[SW-1:0];
    assign c_o = t[SW];
  end else begin : g_pass
    // Empty segment: nothing to add, the carry just rides along.
    assign s_o = '0;
    assign c_o = c_i;
  end

endmodule

// File: rtl/adder_pipe_sat.sv
// Pipelined two's-complement add/subtract unit with optional saturation.
// The carry chain is split into NSEG registered segments (skewed pipeline):
// each stage forwards the untouched operands and the sum bits finished so
// far, and adds its own slice using the carry registered by the stage before.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (a, b, sub)
//   out_valid / out_ready result handshake (sum, carry_out, overflow)
//   sum                   wrapped or saturated result
//   carry_out             raw unsigned carry from the MSB (sub: 1 = no borrow)
//   overflow              signed overflow of the unsaturated result
module adder_pipe_sat
  import adder_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NSEG     = 4,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int          SEG    = seg_size(WIDTH, NSEG);
  localparam int          L      = NSEG - 1;
  localparam logic [63:0] SMAX64 = sat_max(WIDTH);
  localparam logic [63:0] SMIN64 = sat_min(WIDTH);
  localparam logic [WIDTH-1:0] SMAX = SMAX64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SMIN = SMIN64[WIDTH-1:0];

  // Per-stage inputs (from the previous stage or the ports) and registers.
  logic [WIDTH-1:0] a_in  [NSEG];
  logic [WIDTH-1:0] bp_in [NSEG];
  logic [WIDTH-1:0] s_in  [NSEG];
  logic             c_in  [NSEG];
  logic             v_in  [NSEG];
  logic [WIDTH-1:0] s_nx  [NSEG];
  logic             c_nx  [NSEG];
  logic [WIDTH-1:0] s_d   [NSEG];
  logic             vld   [NSEG];
  logic             rdy   [NSEG];
  logic             load  [NSEG];

  logic [WIDTH-1:0] a_q   [NSEG];
  logic [WIDTH-1:0] bp_q  [NSEG];
  logic [WIDTH-1:0] s_q   [NSEG];
  logic             c_q   [NSEG];
  logic             ov_q;
  logic             ov_d;

  // Subtraction is a + ~b + 1: invert b here, the +1 enters as carry-in.
  logic [WIDTH-1:0] b_cond;
  assign b_cond = sub ? ~b : b;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int LO  = seg_lo(k, SEG);
    localparam int SW  = seg_w(k, SEG, WIDTH);
    localparam int SWP = (SW > 0) ? SW : 1;
    localparam int LOS = (SW > 0) ? LO : 0;

    logic           dn_rdy;
    logic [SWP-1:0] seg_s;

    if (k == 0) begin : g_first
      assign a_in[k]  = a;
      assign bp_in[k] = b_cond;
      assign s_in[k]  = '0;
      assign c_in[k]  = sub;
      assign v_in[k]  = in_valid;
    end else begin : g_next
      assign a_in[k]  = a_q[k-1];
      assign bp_in[k] = bp_q[k-1];
      assign s_in[k]  = s_q[k-1];
      assign c_in[k]  = c_q[k-1];
      assign v_in[k]  = vld[k-1];
    end

    if (k == L) begin : g_dn_out
      assign dn_rdy = out_ready;
    end else begin : g_dn_stage
      assign dn_rdy = rdy[k+1];
    end

    adder_seg #(.SW(SW)) u_seg (
      .clk          (clk),
      .rst_n        (rst_n),
      .valid_i      (v_in[k]),
      .down_ready_i (dn_rdy),
      .valid_o      (vld[k]),
      .ready_o      (rdy[k]),
      .load_o       (load[k]),
      .a_i          (a_in[k][LOS +: SWP]),
      .b_i          (bp_in[k][LOS +: SWP]),
      .c_i          (c_in[k]),
      .s_o          (seg_s),
      .c_o          (c_nx[k])
    );

    if (SW > 0) begin : g_merge
      logic [WIDTH-1:0] s_loc;
      always_comb begin
        s_loc           = s_in[k];
        s_loc[LO +: SW] = seg_s;
      end
      assign s_nx[k] = s_loc;
    end else begin : g_keep
      assign s_nx[k] = s_in[k];
    end
  end

  // Final stage: signed overflow of the raw sum, then optional clamp.
  assign ov_d = (a_in[L][WIDTH-1] == bp_in[L][WIDTH-1]) &
                (s_nx[L][WIDTH-1] != a_in[L][WIDTH-1]);

  always_comb begin
    for (int k = 0; k < NSEG; k++) s_d[k] = s_nx[k];
    if ((SATURATE != 0) && ov_d) s_d[L] = a_in[L][WIDTH-1] ? SMIN : SMAX;
  end

  // Stage registers; data only moves on load so stalled stages hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSEG; k++) begin
        a_q[k]  <= '0;
        bp_q[k] <= '0;
        s_q[k]  <= '0;
        c_q[k]  <= 1'b0;
      end
      ov_q <= 1'b0;
    end else begin
      for (int k = 0; k < NSEG; k++) begin
        if (load[k]) begin
          // The last stage has no successor that needs the operands.
          if (k < L) begin
            a_q[k]  <= a_in[k];
            bp_q[k] <= bp_in[k];
          end
          s_q[k] <= s_d[k];
          c_q[k] <= c_nx[k];
        end
      end
      if (load[L]) ov_q <= ov_d;
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[L];
  assign sum       = s_q[L];
  assign carry_out = c_q[L];
  assign overflow  = ov_q;

endmodule

// File: tb/tb_adder_pipe_sat.sv
module tb_adder_pipe_sat;

  localparam int W    = 23;
  localparam int NSEG = 4;
  localparam int SAT  = 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, sub;
  logic         out_valid, out_ready, carry_out, overflow;
  logic [W-1:0] a, b, sum;

  always #5 clk = ~clk;

  adder_pipe_sat #(.WIDTH(W), .NSEG(NSEG), .SATURATE(SAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         ov;
    int           t;
  } exp_t;

  exp_t q[$];
  int   emit_log[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_acc = 0;
  bit   acc_now = 0;
  bit   lat_chk = 0;
  bit   held_v  = 0;
  logic [W-1:0] held_s;
  logic held_c, held_ov;
  exp_t em;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference: signed integer arithmetic on the mathematical values.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts);
    exp_t   e;
    longint full, hi, lo, ua, ub, sa, sb, r;
    full = longint'(1) <<< W;
    hi   = (full >>> 1) - 1;
    lo   = -(full >>> 1);
    ua   = longint'(ta);
    ub   = longint'(tb_);
    sa   = ta[W-1] ? ua - full : ua;
    sb   = tb_[W-1] ? ub - full : ub;
    r    = ts ? sa - sb : sa + sb;
    e.ov = (r > hi) || (r < lo);
    e.c  = ts ? (ua >= ub) : (ua + ub >= full);
    if (SAT != 0 && e.ov) r = (r > hi) ? hi : lo;
    e.s  = r[W-1:0];
    e.t  = 0;
    return e;
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return {1'b0, {(W-1){1'b1}}};
      2: return {1'b1, {(W-1){1'b0}}};
      3: return '1;
      default: return W'($urandom);
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: transfers are decided by values stable since posedge+1.
  always @(negedge clk) begin
    acc_now = 0;
    if (!rst_n) begin
      q.delete();
      held_v = 0;
    end else begin
      if (held_v) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_sum", 64'(sum), 64'(held_s));
        chk("hold_carry", 64'(carry_out), 64'(held_c));
        chk("hold_ovf", 64'(overflow), 64'(held_ov));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 64'(out_valid), 64'(0));
        end else begin
          em = q.pop_front();
          chk("sb_sum", 64'(sum), 64'(em.s));
          chk("sb_carry", 64'(carry_out), 64'(em.c));
          chk("sb_ovf", 64'(overflow), 64'(em.ov));
          if (lat_chk) chk("latency", 64'(cyc - em.t), 64'(NSEG));
          emit_log.push_back(cyc);
        end
      end
      held_v  = out_valid && !out_ready;
      held_s  = sum;
      held_c  = carry_out;
      held_ov = overflow;
      if (in_valid && in_ready) begin
        em   = model(a, b, sub);
        em.t = cyc;
        q.push_back(em);
        acc_now = 1;
        n_acc++;
      end
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts);
    int i;
    a = ta; b = tb_; sub = ts; in_valid = 1'b1;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (i == 200) chk("send_timeout", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic ts, input logic [W-1:0] es, input logic ec, input logic eo);
    send(ta, tb_, ts);
    for (int i = 0; i < 64; i++) begin
      if (out_valid) break;
      @(posedge clk); #1;
    end
    chk({tag, "_valid"}, 64'(out_valid), 64'(1));
    chk({tag, "_sum"}, 64'(sum), 64'(es));
    chk({tag, "_carry"}, 64'(carry_out), 64'(ec));
    chk({tag, "_ovf"}, 64'(overflow), 64'(eo));
    @(posedge clk); #1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, start, seen;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_sum", 64'(sum), 64'(0));
    chk("rst_carry", 64'(carry_out), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 64'(in_ready), 64'(1));

    // Directed corner cases, one at a time, exact latency.
    lat_chk = 1;
    directed("one_plus_one", 23'h000001, 23'h000001, 1'b0, 23'h000002, 1'b0, 1'b0);
    directed("neg1_plus_1",  23'h7FFFFF, 23'h000001, 1'b0, 23'h000000, 1'b1, 1'b0);
    directed("max_plus_1",   23'h3FFFFF, 23'h000001, 1'b0,
             (SAT != 0) ? 23'h3FFFFF : 23'h400000, 1'b0, 1'b1);
    directed("min_minus_1",  23'h400000, 23'h000001, 1'b1,
             (SAT != 0) ? 23'h400000 : 23'h3FFFFF, 1'b1, 1'b1);
    directed("zero_minus_1", 23'h000000, 23'h000001, 1'b1, 23'h7FFFFF, 1'b0, 1'b0);
    directed("min_plus_min", 23'h400000, 23'h400000, 1'b0,
             (SAT != 0) ? 23'h400000 : 23'h000000, 1'b1, 1'b1);
    directed("x_minus_x",    23'h123456, 23'h123456, 1'b1, 23'h000000, 1'b1, 1'b0);

    // Back-to-back burst of 8 with the consumer always ready.
    emit_log.delete();
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = rand_op(); b = rand_op(); sub = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("burst_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (NSEG + 4) @(posedge clk);
    #1;
    chk("burst_count", 64'(emit_log.size()), 64'(8));
    if (emit_log.size() >= 8)
      for (int i = 0; i < 7; i++)
        chk("burst_consecutive", 64'(emit_log[i+1] - emit_log[i]), 64'(1));
    lat_chk = 0;

    // Consumer stalls: pipeline fills, then backpressures the source.
    out_ready = 1'b0;
    n0 = n_acc;
    a = rand_op(); b = rand_op(); sub = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    for (int i = 0; i < NSEG + 2; i++) begin
      @(posedge clk); #1;
      if (acc_now) begin a = rand_op(); b = rand_op(); sub = 1'($urandom_range(0, 1)); end
    end
    chk("stall_accepts", 64'(n_acc - n0), 64'(NSEG));
    chk("stall_in_ready", 64'(in_ready), 64'(0));
    chk("stall_out_valid", 64'(out_valid), 64'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (acc_now) break;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("stall_drained", 64'(q.size()), 64'(0));

    // Reset with three operations in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = rand_op(); b = 23'h000101; sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (out_valid) break;
      @(posedge clk); #1;
    end
    chk("pre_rst_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_sum", 64'(sum), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < NSEG + 4; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("no_stale_after_rst", 64'(seen), 64'(0));
    @(posedge clk); #1;

    // Randomised traffic against the scoreboard.
    start = n_acc;
    in_valid = 1'b0;
    for (int i = 0; i < 60000 && (n_acc - start) < 10000; i++) begin
      if (!in_valid || acc_now) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a = rand_op(); b = rand_op(); sub = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("rand_ops", 64'(n_acc - start), 64'(10000));
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("rand_drained", 64'(q.size()), 64'(0));
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
